// File: rtl/twiddle_operand_select_if.sv
// ---------------------------------------------------------------------------
// twiddle_operand_select_if
//
// Bundle between the FFT sequencer (master) and the operand-fetch stage
// (slave). Carries the request (enable, three 6-bit indices, the flattened
// stage register file) and the registered butterfly operands.
//
// Signals:
//   en        capture enable
//   idx_a     read index, port A (current element)
//   idx_b     read index, port B (partner element)
//   tw_idx    twiddle index k
//   regs_re   flattened real parts, entry i at [i*DATA_W +: DATA_W]
//   regs_im   flattened imaginary parts, same packing
//   conj      select W* (present only when TWSEL_CONJ_EN is defined)
//   a_re/a_im entry idx_a,  b_re/b_im entry idx_b
//   tw_re     twiddle real part (signed Q1.8)
//   tw_im     twiddle imaginary part (signed Q1.8)
//   valid     outputs hold a fresh capture
//
// Optional feature macro: TWSEL_CONJ_EN
// ---------------------------------------------------------------------------
interface twiddle_operand_select_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int TW_W   = 10
);
    logic                     en;
    logic [5:0]               idx_a;
    logic [5:0]               idx_b;
    logic [5:0]               tw_idx;
    logic [DEPTH*DATA_W-1:0]  regs_re;
    logic [DEPTH*DATA_W-1:0]  regs_im;
`ifdef TWSEL_CONJ_EN
    logic                     conj;
`endif
    logic [DATA_W-1:0]        a_re;
    logic [DATA_W-1:0]        a_im;
    logic [DATA_W-1:0]        b_re;
    logic [DATA_W-1:0]        b_im;
    logic signed [TW_W-1:0]   tw_re;
    logic signed [TW_W-1:0]   tw_im;
    logic                     valid;

    modport master (
        output en, idx_a, idx_b, tw_idx, regs_re, regs_im,
`ifdef TWSEL_CONJ_EN
        output conj,
`endif
        input  a_re, a_im, b_re, b_im, tw_re, tw_im, valid
    );

    modport slave (
        input  en, idx_a, idx_b, tw_idx, regs_re, regs_im,
`ifdef TWSEL_CONJ_EN
        input  conj,
`endif
        output a_re, a_im, b_re, b_im, tw_re, tw_im, valid
    );
endinterface

// File: rtl/twiddle_operand_select.sv
// ---------------------------------------------------------------------------
// twiddle_operand_select
//
// Operand-fetch stage of the 64-point radix-2 FFT butterfly. Reads the
// butterfly pair from the stage register file through two independent
// combinational read ports, looks up W = e^(-j*2*pi*k/64) in a quarter-wave
// sine ROM, and registers everything with one cycle of latency.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset; clears all outputs and valid
//   bus   twiddle_operand_select_if.slave (request in, operands out)
//
// Optional feature macro: TWSEL_CONJ_EN
//   Defined:   bus.conj=1 captures tw_im = +sin (W*, inverse FFT).
//   Undefined: tw_im is always -sin.
// ---------------------------------------------------------------------------
module twiddle_operand_select #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int TW_W   = 10
) (
    input  logic clk,
    input  logic rst,
    twiddle_operand_select_if.slave bus
);

    // First quadrant of round(256*sin(2*pi*r/64)), r = 0..16. The other
    // three quadrants are derived by mirroring and negation.
    function automatic logic signed [TW_W-1:0] quarter_sine(input logic [4:0] r);
        case (r)
            5'd0:    return TW_W'(0);
            5'd1:    return TW_W'(25);
            5'd2:    return TW_W'(50);
            5'd3:    return TW_W'(74);
            5'd4:    return TW_W'(98);
            5'd5:    return TW_W'(121);
            5'd6:    return TW_W'(142);
            5'd7:    return TW_W'(162);
            5'd8:    return TW_W'(181);
            5'd9:    return TW_W'(198);
            5'd10:   return TW_W'(213);
            5'd11:   return TW_W'(226);
            5'd12:   return TW_W'(237);
            5'd13:   return TW_W'(245);
            5'd14:   return TW_W'(251);
            5'd15:   return TW_W'(255);
            5'd16:   return TW_W'(256);
            default: return TW_W'(0);
        endcase
    endfunction

    // T[m] for m = 0..63: m[4] mirrors within the half-period, m[5] negates.
    function automatic logic signed [TW_W-1:0] sine_rom(input logic [5:0] m);
        logic [4:0]             r;
        logic signed [TW_W-1:0] mag;
        r   = m[4] ? (5'd16 - {1'b0, m[3:0]}) : {1'b0, m[3:0]};
        mag = quarter_sine(r);
        return m[5] ? -mag : mag;
    endfunction

    // Flat mux over the populated entries; an index at or beyond DEPTH
    // matches nothing and falls through to zero.
    function automatic logic [DATA_W-1:0] read_entry(
        input logic [DEPTH*DATA_W-1:0] flat,
        input logic [5:0]              idx
    );
        logic [DATA_W-1:0] word;
        // NOTE: default assigned before the loop so every path drives word;
        // without it the out-of-range case would infer a latch.
        word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == 6'(i)) begin
                word = flat[i*DATA_W +: DATA_W];
            end
        end
        return word;
    endfunction

    // 6-bit index arithmetic wraps mod 64 by construction.
    logic [5:0] cos_idx;
    logic [5:0] sin_idx;

    always_comb begin
        cos_idx = bus.tw_idx + 6'd16;
        sin_idx = bus.tw_idx + 6'd32;
`ifdef TWSEL_CONJ_EN
        if (bus.conj) begin
            sin_idx = bus.tw_idx;
        end
`endif
    end

    logic [DATA_W-1:0]      nxt_a_re;
    logic [DATA_W-1:0]      nxt_a_im;
    logic [DATA_W-1:0]      nxt_b_re;
    logic [DATA_W-1:0]      nxt_b_im;
    logic signed [TW_W-1:0] nxt_tw_re;
    logic signed [TW_W-1:0] nxt_tw_im;

    always_comb begin
        nxt_a_re  = read_entry(bus.regs_re, bus.idx_a);
        nxt_a_im  = read_entry(bus.regs_im, bus.idx_a);
        nxt_b_re  = read_entry(bus.regs_re, bus.idx_b);
        nxt_b_im  = read_entry(bus.regs_im, bus.idx_b);
        nxt_tw_re = sine_rom(cos_idx);
        nxt_tw_im = sine_rom(sin_idx);
    end

    // NOTE: non-blocking assignments so every output register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.a_re  <= '0;
            bus.a_im  <= '0;
            bus.b_re  <= '0;
            bus.b_im  <= '0;
            bus.tw_re <= '0;
            bus.tw_im <= '0;
            bus.valid <= 1'b0;
        end else if (bus.en) begin
            bus.a_re  <= nxt_a_re;
            bus.a_im  <= nxt_a_im;
            bus.b_re  <= nxt_b_re;
            bus.b_im  <= nxt_b_im;
            bus.tw_re <= nxt_tw_re;
            bus.tw_im <= nxt_tw_im;
            bus.valid <= 1'b1;
        end else begin
            // Data holds; valid marks the outputs as stale.
            bus.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_twiddle_operand_select.sv
// ---------------------------------------------------------------------------
// tb_twiddle_operand_select
//
// Directed bench for twiddle_operand_select. A reference model (real-valued
// sine, rounded half away from zero) predicts each capture; predictions are
// queued when a request is driven and popped when the registered result
// appears one edge later. Set TWSEL_CONJ_EN to cover the conjugate option.
// ---------------------------------------------------------------------------
module tb_twiddle_operand_select;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;
    localparam int TW_W   = 10;

    typedef struct packed {
        logic [DATA_W-1:0]      a_re;
        logic [DATA_W-1:0]      a_im;
        logic [DATA_W-1:0]      b_re;
        logic [DATA_W-1:0]      b_im;
        logic signed [TW_W-1:0] tw_re;
        logic signed [TW_W-1:0] tw_im;
    } exp_t;

    logic clk;
    logic rst;

    twiddle_operand_select_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TW_W(TW_W)) bus ();

    twiddle_operand_select #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TW_W(TW_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t held;

    logic [DATA_W-1:0] mem_re [DEPTH];
    logic [DATA_W-1:0] mem_im [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e, input logic v);
        check({tag, ".a_re"},  32'(bus.a_re),  32'(e.a_re));
        check({tag, ".a_im"},  32'(bus.a_im),  32'(e.a_im));
        check({tag, ".b_re"},  32'(bus.b_re),  32'(e.b_re));
        check({tag, ".b_im"},  32'(bus.b_im),  32'(e.b_im));
        check({tag, ".tw_re"}, 32'(bus.tw_re), 32'(e.tw_re));
        check({tag, ".tw_im"}, 32'(bus.tw_im), 32'(e.tw_im));
        check({tag, ".valid"}, 32'(bus.valid), 32'(v));
    endtask

    // 256*sin(2*pi*m/64), rounded half away from zero.
    function automatic int tsin(input int m);
        real x;
        x = 256.0 * $sin(2.0 * 3.14159265358979 * real'(m) / 64.0);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic logic [DATA_W-1:0] mem_read(input logic re, input logic [5:0] idx);
        if (int'(idx) >= DEPTH) return '0;
        return re ? mem_re[idx] : mem_im[idx];
    endfunction

    function automatic exp_t model();
        exp_t e;
        int   k;
        logic conj_sel;
        conj_sel = 1'b0;
`ifdef TWSEL_CONJ_EN
        conj_sel = bus.conj;
`endif
        k       = int'(bus.tw_idx);
        e.a_re  = mem_read(1'b1, bus.idx_a);
        e.a_im  = mem_read(1'b0, bus.idx_a);
        e.b_re  = mem_read(1'b1, bus.idx_b);
        e.b_im  = mem_read(1'b0, bus.idx_b);
        e.tw_re = TW_W'(tsin((k + 16) % 64));
        e.tw_im = conj_sel ? TW_W'(tsin(k)) : TW_W'(tsin((k + 32) % 64));
        return e;
    endfunction

    task automatic pack_regs();
        for (int i = 0; i < DEPTH; i++) begin
            bus.regs_re[i*DATA_W +: DATA_W] = mem_re[i];
            bus.regs_im[i*DATA_W +: DATA_W] = mem_im[i];
        end
    endtask

    // One request: drive at the falling edge, predict, then check one
    // time unit after the rising edge.
    task automatic step(input string tag, input logic e, input logic [5:0] ia,
                        input logic [5:0] ib, input logic [5:0] k);
        @(negedge clk);
        bus.en     = e;
        bus.idx_a  = ia;
        bus.idx_b  = ib;
        bus.tw_idx = k;
        if (e) sb.push_back(model());
        @(posedge clk);
        #1;
        if (e) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
            end
            if (sb.size() != 0) held = sb.pop_front();
        end
        check_all(tag, held, e);
    endtask

    initial begin
        rst        = 1'b0;
        bus.en     = 1'b0;
        bus.idx_a  = '0;
        bus.idx_b  = '0;
        bus.tw_idx = '0;
`ifdef TWSEL_CONJ_EN
        bus.conj   = 1'b0;
`endif
        held = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_re[i] = DATA_W'(i * 3);
            mem_im[i] = ~DATA_W'(i);
        end
        pack_regs();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Register reads and twiddle sweep points.
        step("k0_rd", 1'b1, 6'd5, 6'd37, 6'd0);
        check("k0_rd.a_re_const",  32'(bus.a_re),  32'd15);
        check("k0_rd.b_re_const",  32'(bus.b_re),  32'd111);
        check("k0_rd.a_im_const",  32'(bus.a_im),  32'hFFFA);
        check("k0_rd.b_im_const",  32'(bus.b_im),  32'hFFDA);
        check("k0.tw_re_const",    32'(bus.tw_re), 32'(256));
        check("k0.tw_im_const",    32'(bus.tw_im), 32'(0));

        step("k8_same", 1'b1, 6'd63, 6'd63, 6'd8);
        check("k8.tw_re_const",    32'(bus.tw_re), 32'(181));
        check("k8.tw_im_const",    32'(bus.tw_im), -32'sd181);

        step("k16_zero", 1'b1, 6'd0, 6'd1, 6'd16);
        check("k16.tw_re_const",   32'(bus.tw_re), 32'(0));
        check("k16.tw_im_const",   32'(bus.tw_im), -32'sd256);
        check("idx0.a_re_const",   32'(bus.a_re),  32'd0);

        step("k63_wrap", 1'b1, 6'd10, 6'd20, 6'd63);
        check("k63.tw_re_const",   32'(bus.tw_re), 32'(255));
        check("k63.tw_im_const",   32'(bus.tw_im), 32'(25));

        // Enable hold: inputs and register file change while en=0.
        step("hold_cap", 1'b1, 6'd2, 6'd3, 6'd4);
        for (int c = 0; c < 3; c++) begin
            mem_re[c + 2] = DATA_W'($urandom);
            mem_im[c + 2] = DATA_W'($urandom);
            pack_regs();
            step("hold", 1'b0, 6'(c + 40), 6'(c + 50), 6'(c + 30));
        end
        step("hold_release", 1'b1, 6'd2, 6'd3, 6'd12);

        // Mixed traffic with random enables and register contents.
        for (int n = 0; n < 24; n++) begin
            mem_re[n] = DATA_W'($urandom);
            mem_im[n + 32] = DATA_W'($urandom);
            pack_regs();
            step("rand", 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        end

        // Asynchronous reset in the middle of an enabled stream.
        step("pre_rst", 1'b1, 6'd7, 6'd9, 6'd20);
        @(negedge clk);
        bus.en    = 1'b1;
        bus.idx_a = 6'd11;
        #2;
        rst = 1'b0;
        #1;
        held = '0;
        sb.delete();
        check_all("rst_async", '0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all("rst_held", '0, 1'b0);
        end
        @(negedge clk);
        rst    = 1'b1;
        bus.en = 1'b0;
        step("post_rst_idle", 1'b0, 6'd11, 6'd12, 6'd5);
        step("post_rst_cap", 1'b1, 6'd11, 6'd12, 6'd5);

`ifdef TWSEL_CONJ_EN
        bus.conj = 1'b1;
        step("conj1", 1'b1, 6'd1, 6'd2, 6'd8);
        check("conj1.tw_re_const", 32'(bus.tw_re), 32'(181));
        check("conj1.tw_im_const", 32'(bus.tw_im), 32'(181));
        bus.conj = 1'b0;
        step("conj0", 1'b1, 6'd1, 6'd2, 6'd8);
        check("conj0.tw_im_const", 32'(bus.tw_im), -32'sd181);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
